alu_iterative_exec: RTL

//  Execute-side consumer of the 4-bit ALUControl code produced by the ALU decoder.
//  It takes operands plus ALUControl over a valid/ready handshake and returns a result.

---
 rtl/alu_iterative_exec.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_iterative_exec.sv
// rtl/alu_iterative_exec.sv - EX-stage ALU with single-cycle logic/arith ops and bit-serial shifts
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands/op valid
//   in_ready   unit can accept a new op this cycle (EX stall when low)
//   alu_ctrl   4-bit ALUControl code
//   src_a      operand A
//   src_b      operand B; shift amount is src_b[4:0]
//   out_valid  result valid
//   out_ready  downstream accepts result
//   result     ALU result
//   zero       result == 0
//   illegal    alu_ctrl outside the encoding table; result forced to 0

module alu_iterative_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    logic [1:0]      state;
    logic [XLEN-1:0] work;
    logic [4:0]      cnt;
    logic [3:0]      op_q;
    logic            illegal_q;

    logic            accept;
    logic            is_shift;
    logic            is_legal;
    logic [4:0]      shamt;
    logic [XLEN-1:0] single_result;
    logic [XLEN-1:0] shift_next;

    // In DONE the unit can take a new op in the same cycle the result drains.
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign result    = work;
    assign zero      = (work == '0);
    assign illegal   = illegal_q;

    assign shamt    = src_b[4:0];
    assign is_legal = (alu_ctrl <= OP_SRA);
    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

    always_comb begin
        single_result = '0;
        case (alu_ctrl)
            OP_ADD:  single_result = src_a + src_b;
            OP_SUB:  single_result = src_a - src_b;
            OP_AND:  single_result = src_a & src_b;
            OP_OR:   single_result = src_a | src_b;
            OP_SLT:  single_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: single_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  single_result = src_a ^ src_b;
            // Shifts are loaded as src_a and worked on in SHIFT; illegal codes yield 0.
            default: single_result = is_shift ? src_a : '0;
        endcase
    end

    // One-bit step of the working register for the latched shift kind.
    always_comb begin
        shift_next = work;
        case (op_q)
            OP_SLL:  shift_next = {work[XLEN-2:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, work[XLEN-1:1]};
            OP_SRA:  shift_next = {work[XLEN-1], work[XLEN-1:1]};
            default: shift_next = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            work      <= '0;
            cnt       <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        illegal_q <= !is_legal;
                        work      <= single_result;
                        if (is_shift && (shamt != 5'd0)) begin
                            cnt   <= shamt;
                            op_q  <= alu_ctrl;
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (state == ST_DONE && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work <= shift_next;
                    cnt  <= cnt - 5'd1;
                    // Count reaches zero with this shift: the result is complete.
                    if (cnt == 5'd1) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
